// File: rtl/rx_interrupt_ctrl_if.sv
// Host register bus between the PCIe target path and rx_interrupt_ctrl.
// master: host side drives strobes/addr/data; slave: register block returns read data.
interface rx_interrupt_ctrl_if;
   logic        reg_wr_en;
   logic [3:0]  reg_wr_addr;
   logic [31:0] reg_wr_data;
   logic        reg_rd_en;
   logic [3:0]  reg_rd_addr;
   logic [31:0] reg_rd_data;
   logic        reg_rd_valid;

   modport master (
      output reg_wr_en, reg_wr_addr, reg_wr_data,
      output reg_rd_en, reg_rd_addr,
      input  reg_rd_data, reg_rd_valid
   );

   modport slave (
      input  reg_wr_en, reg_wr_addr, reg_wr_data,
      input  reg_rd_en, reg_rd_addr,
      output reg_rd_data, reg_rd_valid
   );
endinterface

// File: rtl/rx_interrupt_ctrl.sv
// RX interrupt control/status registers: enable, moderation period, resend
// request handshake and huge page ownership tracking.
// Ports: clk, reset (sync, active-high), bus (host register slave port),
// hp_close_1/2 from DMA, resend_interrupt_ack from the interrupt generator,
// interrupts_enabled / interrupt_period / resend_interrupt / huge_page_status_1/2 out.
module rx_interrupt_ctrl #(
   parameter logic [31:0] DEFAULT_PERIOD = 32'd50000,
   parameter logic [31:0] MIN_PERIOD     = 32'd16
) (
   input  logic                clk,
   input  logic                reset,
   rx_interrupt_ctrl_if.slave  bus,
   input  logic                hp_close_1,
   input  logic                hp_close_2,
   output logic                interrupts_enabled,
   output logic [31:0]         interrupt_period,
   output logic                resend_interrupt,
   input  logic                resend_interrupt_ack,
   output logic                huge_page_status_1,
   output logic                huge_page_status_2
);

   localparam logic [3:0] A_CTRL   = 4'd0;
   localparam logic [3:0] A_PERIOD = 4'd1;
   localparam logic [3:0] A_RESEND = 4'd2;
   localparam logic [3:0] A_HP_REL = 4'd3;
   localparam logic [3:0] A_HP_OVR = 4'd4;

   logic        en_q;
   logic [31:0] period_q;
   logic        pend_q;
   logic [15:0] cnt_q;
   logic        st1_q, st2_q;
   logic        ovr1_q, ovr2_q;
   logic [31:0] rd_data_q;
   logic        rd_valid_q;
   logic [31:0] rd_mux;

   logic wr_ctrl, wr_period, wr_resend, wr_rel, wr_ovr;
   logic rel1, rel2, clr1, clr2;
   logic set_ovr1, set_ovr2;

   assign wr_ctrl   = bus.reg_wr_en && (bus.reg_wr_addr == A_CTRL);
   assign wr_period = bus.reg_wr_en && (bus.reg_wr_addr == A_PERIOD);
   assign wr_resend = bus.reg_wr_en && (bus.reg_wr_addr == A_RESEND);
   assign wr_rel    = bus.reg_wr_en && (bus.reg_wr_addr == A_HP_REL);
   assign wr_ovr    = bus.reg_wr_en && (bus.reg_wr_addr == A_HP_OVR);

   assign rel1 = wr_rel && bus.reg_wr_data[0];
   assign rel2 = wr_rel && bus.reg_wr_data[1];
   assign clr1 = wr_ovr && bus.reg_wr_data[0];
   assign clr2 = wr_ovr && bus.reg_wr_data[1];

   // A close that races a release of the same page is a legal hand-back,
   // so it must not be flagged as an overrun.
   assign set_ovr1 = hp_close_1 && st1_q && !rel1;
   assign set_ovr2 = hp_close_2 && st2_q && !rel2;

   always_comb begin
      rd_mux = '0;
      case (bus.reg_rd_addr)
         A_CTRL:   rd_mux = {31'b0, en_q};
         A_PERIOD: rd_mux = period_q;
         A_RESEND: rd_mux = {pend_q, 15'b0, cnt_q};
         A_HP_REL: rd_mux = {28'b0, ovr2_q, ovr1_q, st2_q, st1_q};
         default:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en_q       <= 1'b0;
         period_q   <= DEFAULT_PERIOD;
         pend_q     <= 1'b0;
         cnt_q      <= '0;
         st1_q      <= 1'b0;
         st2_q      <= 1'b0;
         ovr1_q     <= 1'b0;
         ovr2_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= bus.reg_rd_en;
         if (bus.reg_rd_en)
            rd_data_q <= rd_mux;

         if (wr_ctrl)
            en_q <= bus.reg_wr_data[0];

         if (wr_period)
            period_q <= (bus.reg_wr_data < MIN_PERIOD) ?
                        MIN_PERIOD : bus.reg_wr_data;

         // A new request beats a same-cycle ack of the previous one.
         if (wr_resend) begin
            pend_q <= 1'b1;
            cnt_q  <= cnt_q + 16'd1;
         end else if (resend_interrupt_ack) begin
            pend_q <= 1'b0;
         end

         if (hp_close_1)
            st1_q <= 1'b1;
         else if (rel1)
            st1_q <= 1'b0;

         if (hp_close_2)
            st2_q <= 1'b1;
         else if (rel2)
            st2_q <= 1'b0;

         if (set_ovr1)
            ovr1_q <= 1'b1;
         else if (clr1)
            ovr1_q <= 1'b0;

         if (set_ovr2)
            ovr2_q <= 1'b1;
         else if (clr2)
            ovr2_q <= 1'b0;
      end
   end

   assign bus.reg_rd_data  = rd_data_q;
   assign bus.reg_rd_valid = rd_valid_q;

   assign interrupts_enabled = en_q;
   assign interrupt_period   = period_q;
   assign resend_interrupt   = pend_q;
   assign huge_page_status_1 = st1_q;
   assign huge_page_status_2 = st2_q;

endmodule

// File: tb/tb_rx_interrupt_ctrl.sv
// Self-checking bench for rx_interrupt_ctrl: register vector table,
// handshake / page-ownership sequences and a randomized model comparison.
module tb_rx_interrupt_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic        hp_close_1, hp_close_2;
   logic        interrupts_enabled;
   logic [31:0] interrupt_period;
   logic        resend_interrupt;
   logic        resend_interrupt_ack;
   logic        huge_page_status_1, huge_page_status_2;

   int n_cmp = 0;
   int n_err = 0;

   rx_interrupt_ctrl_if bus ();

   rx_interrupt_ctrl dut (
      .clk                  (clk),
      .reset                (reset),
      .bus                  (bus),
      .hp_close_1           (hp_close_1),
      .hp_close_2           (hp_close_2),
      .interrupts_enabled   (interrupts_enabled),
      .interrupt_period     (interrupt_period),
      .resend_interrupt     (resend_interrupt),
      .resend_interrupt_ack (resend_interrupt_ack),
      .huge_page_status_1   (huge_page_status_1),
      .huge_page_status_2   (huge_page_status_2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic [3:0]  ra;
      logic [31:0] exp_rd;
      logic        exp_en;
      logic [31:0] exp_per;
   } vec_t;

   vec_t vt[16];

   // behavioural model state for the random phase
   logic        m_en, m_pend, m_s1, m_s2, m_o1, m_o2;
   logic [31:0] m_per, m_rd;
   logic [15:0] m_cnt;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.reg_wr_en = 1'b0;
      bus.reg_rd_en = 1'b0;
      hp_close_1 = 1'b0;
      hp_close_2 = 1'b0;
      resend_interrupt_ack = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      bus.reg_wr_en   = 1'b1;
      bus.reg_wr_addr = a;
      bus.reg_wr_data = d;
      step();
      bus.reg_wr_en = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [3:0] a,
                         input logic [31:0] exp);
      bus.reg_rd_en   = 1'b1;
      bus.reg_rd_addr = a;
      step();
      bus.reg_rd_en = 1'b0;
      check({nm, "_valid"}, {31'b0, bus.reg_rd_valid}, 32'd1);
      check(nm, bus.reg_rd_data, exp);
   endtask

   function automatic logic [31:0] model_read(input logic [3:0] a);
      case (a)
         4'd0:    return {31'b0, m_en};
         4'd1:    return m_per;
         4'd2:    return {m_pend, 15'b0, m_cnt};
         4'd3:    return {28'b0, m_o2, m_o1, m_s2, m_s1};
         default: return 32'h0;
      endcase
   endfunction

   initial begin
      logic [15:0] cnt;
      int          n;
      reset = 1'b1;
      bus.reg_wr_addr = '0;
      bus.reg_wr_data = '0;
      bus.reg_rd_addr = '0;
      idle();
      step();
      step();
      reset = 1'b0;

      check("rst_en", {31'b0, interrupts_enabled}, 32'd0);
      check("rst_period", interrupt_period, 32'd50000);
      check("rst_resend", {31'b0, resend_interrupt}, 32'd0);
      check("rst_hp", {30'b0, huge_page_status_2, huge_page_status_1}, 32'd0);
      check("rst_rd_valid", {31'b0, bus.reg_rd_valid}, 32'd0);
      check("rst_rd_data", bus.reg_rd_data, 32'd0);

      //        we    wa     wd            ra     exp_rd        en    per
      vt[0]  = '{1'b0, 4'd0, 32'd0,        4'd0,  32'd0,        1'b0, 32'd50000};
      vt[1]  = '{1'b0, 4'd0, 32'd0,        4'd1,  32'd50000,    1'b0, 32'd50000};
      vt[2]  = '{1'b0, 4'd0, 32'd0,        4'd2,  32'd0,        1'b0, 32'd50000};
      vt[3]  = '{1'b0, 4'd0, 32'd0,        4'd3,  32'd0,        1'b0, 32'd50000};
      vt[4]  = '{1'b0, 4'd0, 32'd0,        4'd4,  32'd0,        1'b0, 32'd50000};
      vt[5]  = '{1'b1, 4'd1, 32'd5,        4'd1,  32'd50000,    1'b0, 32'd16};
      vt[6]  = '{1'b0, 4'd0, 32'd0,        4'd1,  32'd16,       1'b0, 32'd16};
      vt[7]  = '{1'b1, 4'd1, 32'd1000,     4'd1,  32'd16,       1'b0, 32'd1000};
      vt[8]  = '{1'b1, 4'd0, 32'd1,        4'd0,  32'd0,        1'b1, 32'd1000};
      vt[9]  = '{1'b0, 4'd0, 32'd0,        4'd0,  32'd1,        1'b1, 32'd1000};
      vt[10] = '{1'b1, 4'd0, 32'hFFFFFFFE, 4'd0,  32'd1,        1'b0, 32'd1000};
      vt[11] = '{1'b1, 4'd0, 32'd3,        4'd5,  32'd0,        1'b1, 32'd1000};
      vt[12] = '{1'b1, 4'd7, 32'hFFFF,     4'd0,  32'd1,        1'b1, 32'd1000};
      vt[13] = '{1'b1, 4'd1, 32'd16,       4'd1,  32'd1000,     1'b1, 32'd16};
      vt[14] = '{1'b1, 4'd1, 32'd15,       4'd15, 32'd0,        1'b1, 32'd16};
      vt[15] = '{1'b1, 4'd1, 32'd17,       4'd1,  32'd16,       1'b1, 32'd17};

      for (int i = 0; i < 16; i++) begin
         bus.reg_wr_en   = vt[i].we;
         bus.reg_wr_addr = vt[i].wa;
         bus.reg_wr_data = vt[i].wd;
         bus.reg_rd_en   = 1'b1;
         bus.reg_rd_addr = vt[i].ra;
         step();
         check($sformatf("vec%0d_valid", i), {31'b0, bus.reg_rd_valid}, 32'd1);
         check($sformatf("vec%0d_rd", i), bus.reg_rd_data, vt[i].exp_rd);
         check($sformatf("vec%0d_en", i), {31'b0, interrupts_enabled},
               {31'b0, vt[i].exp_en});
         check($sformatf("vec%0d_per", i), interrupt_period, vt[i].exp_per);
      end
      idle();
      step();
      check("idle_valid", {31'b0, bus.reg_rd_valid}, 32'd0);
      check("idle_hold", bus.reg_rd_data, 32'd16);

      // resend with delayed ack
      wr(4'd2, 32'hDEAD);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("resend_hold%0d", i), {31'b0, resend_interrupt}, 32'd1);
         step();
      end
      resend_interrupt_ack = 1'b1;
      step();
      resend_interrupt_ack = 1'b0;
      check("resend_cleared", {31'b0, resend_interrupt}, 32'd0);
      rd_chk("resend_cnt1", 4'd2, 32'h0000_0001);

      // coalescing and write-wins-over-ack
      wr(4'd2, 32'd0);
      resend_interrupt_ack = 1'b1;
      wr(4'd2, 32'd0);
      resend_interrupt_ack = 1'b0;
      check("resend_ack_race", {31'b0, resend_interrupt}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         wr(4'd2, 32'd0);
         check($sformatf("resend_coal%0d", i), {31'b0, resend_interrupt}, 32'd1);
      end
      rd_chk("resend_cnt6", 4'd2, 32'h8000_0006);
      resend_interrupt_ack = 1'b1;
      step();
      resend_interrupt_ack = 1'b0;
      check("resend_clear2", {31'b0, resend_interrupt}, 32'd0);
      resend_interrupt_ack = 1'b1;
      step();
      resend_interrupt_ack = 1'b0;
      check("stray_ack", {31'b0, resend_interrupt}, 32'd0);
      rd_chk("resend_cnt6b", 4'd2, 32'h0000_0006);

      // run the counter up to its wrap point
      cnt = 16'd6;
      n = 65536 - int'(cnt);
      bus.reg_wr_en   = 1'b1;
      bus.reg_wr_addr = 4'd2;
      repeat (n) step();
      bus.reg_wr_en = 1'b0;
      rd_chk("resend_wrap", 4'd2, 32'h8000_0000);

      // huge page ownership
      hp_close_1 = 1'b1;
      step();
      hp_close_1 = 1'b0;
      check("hp1_set", {31'b0, huge_page_status_1}, 32'd1);
      hp_close_1 = 1'b1;
      step();
      hp_close_1 = 1'b0;
      rd_chk("hp1_ovr", 4'd3, 32'h5);
      wr(4'd3, 32'd1);
      check("hp1_rel", {31'b0, huge_page_status_1}, 32'd0);
      rd_chk("hp1_ovr_sticky", 4'd3, 32'h4);
      wr(4'd4, 32'd1);
      rd_chk("hp1_ovr_clr", 4'd3, 32'h0);
      hp_close_2 = 1'b1;
      wr(4'd3, 32'd2);
      hp_close_2 = 1'b0;
      check("hp2_close_wins", {31'b0, huge_page_status_2}, 32'd1);
      rd_chk("hp2_no_ovr", 4'd3, 32'h2);
      hp_close_2 = 1'b1;
      wr(4'd3, 32'd2);
      hp_close_2 = 1'b0;
      rd_chk("hp2_race_held", 4'd3, 32'h2);
      hp_close_1 = 1'b1;
      hp_close_2 = 1'b1;
      step();
      idle();
      rd_chk("hp_both", 4'd3, 32'hB);

      // reset while resend pending
      wr(4'd2, 32'd0);
      check("pre_rst_pend", {31'b0, resend_interrupt}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_drop_resend", {31'b0, resend_interrupt}, 32'd0);
      check("rst_hp2", {30'b0, huge_page_status_2, huge_page_status_1}, 32'd0);
      rd_chk("rst_cnt", 4'd2, 32'h0);
      rd_chk("rst_ovr", 4'd3, 32'h0);

      // randomized comparison against the model
      m_en = 1'b0; m_per = 32'd50000; m_pend = 1'b0; m_cnt = '0;
      m_s1 = 1'b0; m_s2 = 1'b0; m_o1 = 1'b0; m_o2 = 1'b0;
      m_rd = 32'h0;
      for (int i = 0; i < 3000; i++) begin
         logic        we, re, c1, c2, ack;
         logic [3:0]  wa, ra;
         logic [31:0] wd;
         logic        r1, r2, k1, k2, ov1, ov2;
         we  = ($urandom % 2) == 0;
         wa  = 4'($urandom_range(0, 7));
         wd  = (($urandom % 4) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         re  = ($urandom % 2) == 0;
         ra  = 4'($urandom_range(0, 7));
         c1  = ($urandom % 4) == 0;
         c2  = ($urandom % 4) == 0;
         ack = ($urandom % 3) == 0;

         bus.reg_wr_en   = we;
         bus.reg_wr_addr = wa;
         bus.reg_wr_data = wd;
         bus.reg_rd_en   = re;
         bus.reg_rd_addr = ra;
         hp_close_1 = c1;
         hp_close_2 = c2;
         resend_interrupt_ack = ack;

         if (re) m_rd = model_read(ra);
         r1 = we && wa == 4'd3 && wd[0];
         r2 = we && wa == 4'd3 && wd[1];
         k1 = we && wa == 4'd4 && wd[0];
         k2 = we && wa == 4'd4 && wd[1];
         ov1 = c1 && m_s1 && !r1;
         ov2 = c2 && m_s2 && !r2;
         if (we && wa == 4'd0) m_en = wd[0];
         if (we && wa == 4'd1) m_per = (wd < 32'd16) ? 32'd16 : wd;
         if (we && wa == 4'd2) begin
            m_pend = 1'b1;
            m_cnt  = m_cnt + 16'd1;
         end else if (ack) begin
            m_pend = 1'b0;
         end
         if (c1) m_s1 = 1'b1; else if (r1) m_s1 = 1'b0;
         if (c2) m_s2 = 1'b1; else if (r2) m_s2 = 1'b0;
         if (ov1) m_o1 = 1'b1; else if (k1) m_o1 = 1'b0;
         if (ov2) m_o2 = 1'b1; else if (k2) m_o2 = 1'b0;

         step();
         check($sformatf("rnd%0d_valid", i), {31'b0, bus.reg_rd_valid},
               {31'b0, re});
         check($sformatf("rnd%0d_rd", i), bus.reg_rd_data, m_rd);
         check($sformatf("rnd%0d_flags", i),
               {28'b0, interrupts_enabled, resend_interrupt,
                huge_page_status_2, huge_page_status_1},
               {28'b0, m_en, m_pend, m_s2, m_s1});
         check($sformatf("rnd%0d_per", i), interrupt_period, m_per);
      end
      idle();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
